// File: rtl/mem_bus_arbiter.sv
// Arbitrates one 32-bit memory bus between instruction fetch and the MEM-stage data port.
// Round-robin on contention, registered bus cycle held until ack or timeout abort.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  localparam logic GRANT_DATA = 1'b0;
  localparam logic GRANT_INST = 1'b1;
  // Abort fires on the TIMEOUT-th consecutive cycle without bus_ack_i.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_nxt_s;
  logic        last_grant_r, last_grant_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic        d_elig_s, i_elig_s;
  logic        bus_req_nxt_s, bus_we_nxt_s;
  logic [3:0]  bus_sel_nxt_s;
  logic [31:0] bus_addr_nxt_s, bus_wdata_nxt_s;
  logic        if_ack_nxt_s, d_ack_nxt_s, bus_err_nxt_s;
  logic [31:0] if_data_nxt_s, d_rdata_nxt_s;

  assign d_elig_s    = d_req_i & ~d_ack_o;
  assign i_elig_s    = if_req_i & ~if_ack_o;
  assign stall_if_o  = if_req_i & ~if_ack_o;
  assign stall_mem_o = d_req_i & ~d_ack_o;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, grant and completion decode.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    cnt_nxt_s        = cnt_r;
    bus_req_nxt_s    = bus_req_o;
    bus_we_nxt_s     = bus_we_o;
    bus_sel_nxt_s    = bus_sel_o;
    bus_addr_nxt_s   = bus_addr_o;
    bus_wdata_nxt_s  = bus_wdata_o;
    if_ack_nxt_s     = 1'b0;
    d_ack_nxt_s      = 1'b0;
    bus_err_nxt_s    = 1'b0;
    if_data_nxt_s    = if_data_o;
    d_rdata_nxt_s    = d_rdata_o;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 8'd0;
        if (d_elig_s && i_elig_s) begin
          last_grant_nxt_s = ~last_grant_r;
        end else begin
          last_grant_nxt_s = last_grant_r;
        end
        if (d_elig_s && (!i_elig_s || (last_grant_r == GRANT_INST))) begin
          state_nxt_s     = BUSY_D;
          bus_req_nxt_s   = 1'b1;
          bus_we_nxt_s    = d_we_i;
          bus_sel_nxt_s   = d_sel_i;
          bus_addr_nxt_s  = d_addr_i;
          bus_wdata_nxt_s = d_wdata_i;
        end else if (i_elig_s) begin
          state_nxt_s     = BUSY_I;
          bus_req_nxt_s   = 1'b1;
          bus_we_nxt_s    = 1'b0;
          bus_sel_nxt_s   = 4'b1111;
          bus_addr_nxt_s  = if_addr_i;
          bus_wdata_nxt_s = 32'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_D, BUSY_I: begin
        // An ack in the expiry cycle wins over the abort.
        if (bus_ack_i) begin
          state_nxt_s   = IDLE;
          bus_req_nxt_s = 1'b0;
          cnt_nxt_s     = 8'd0;
          if (state_r == BUSY_D) begin
            d_ack_nxt_s   = 1'b1;
            d_rdata_nxt_s = bus_we_o ? 32'd0 : bus_rdata_i;
          end else begin
            if_ack_nxt_s  = 1'b1;
            if_data_nxt_s = bus_rdata_i;
          end
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s   = IDLE;
          bus_req_nxt_s = 1'b0;
          cnt_nxt_s     = 8'd0;
          bus_err_nxt_s = 1'b1;
          if (state_r == BUSY_D) begin
            d_ack_nxt_s   = 1'b1;
            d_rdata_nxt_s = 32'd0;
          end else begin
            if_ack_nxt_s  = 1'b1;
            if_data_nxt_s = 32'd0;
          end
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        bus_req_nxt_s = 1'b0;
        cnt_nxt_s     = 8'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GRANT_INST;
      cnt_r        <= 8'd0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_sel_o    <= 4'd0;
      bus_addr_o   <= 32'd0;
      bus_wdata_o  <= 32'd0;
      if_ack_o     <= 1'b0;
      d_ack_o      <= 1'b0;
      bus_err_o    <= 1'b0;
      if_data_o    <= 32'd0;
      d_rdata_o    <= 32'd0;
    end else begin
      last_grant_r <= last_grant_nxt_s;
      cnt_r        <= cnt_nxt_s;
      bus_req_o    <= bus_req_nxt_s;
      bus_we_o     <= bus_we_nxt_s;
      bus_sel_o    <= bus_sel_nxt_s;
      bus_addr_o   <= bus_addr_nxt_s;
      bus_wdata_o  <= bus_wdata_nxt_s;
      if_ack_o     <= if_ack_nxt_s;
      d_ack_o      <= d_ack_nxt_s;
      bus_err_o    <= bus_err_nxt_s;
      if_data_o    <= if_data_nxt_s;
      d_rdata_o    <= d_rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: read, contention round-robin, write, timeout, reset abort.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'd0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_sel_i = 4'b1111; d_addr_i = 32'd0; d_wdata_i = 32'd0; bus_rdata_i = 32'd0; bus_ack_i = 1'b0;
    tick(); tick();
    check_eq("rst_bus_req", 32'(bus_req_o), 32'd0);
    check_eq("rst_d_ack", 32'(d_ack_o), 32'd0);
    check_eq("rst_if_ack", 32'(if_ack_o), 32'd0);
    check_eq("rst_err", 32'(bus_err_o), 32'd0);
    check_eq("rst_d_rdata", d_rdata_o, 32'd0);
    check_eq("rst_if_data", if_data_o, 32'd0);
    rst = 1'b0;

    // 1: data read, ack two cycles after bus_req_o
    d_req_i = 1'b1; d_addr_i = 32'h100; #1;
    check_eq("t1_stall_c0", 32'(stall_mem_o), 32'd1);
    tick();
    check_eq("t1_bus_req", 32'(bus_req_o), 32'd1);
    check_eq("t1_bus_addr", bus_addr_o, 32'h100);
    check_eq("t1_bus_we", 32'(bus_we_o), 32'd0);
    tick();
    check_eq("t1_stall_c2", 32'(stall_mem_o), 32'd1);
    check_eq("t1_no_ack_c2", 32'(d_ack_o), 32'd0);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t1_d_ack", 32'(d_ack_o), 32'd1);
    check_eq("t1_d_rdata", d_rdata_o, 32'hDEADBEEF);
    check_eq("t1_bus_req_drop", 32'(bus_req_o), 32'd0);
    check_eq("t1_stall_off", 32'(stall_mem_o), 32'd0);
    check_eq("t1_if_ack", 32'(if_ack_o), 32'd0);
    check_eq("t1_err", 32'(bus_err_o), 32'd0);
    d_req_i = 1'b0;
    tick();
    check_eq("t1_ack_pulse", 32'(d_ack_o), 32'd0);
    check_eq("t1_rdata_hold", d_rdata_o, 32'hDEADBEEF);
    check_eq("t1_no_regrant", 32'(bus_req_o), 32'd0);

    // 2: contention after reset -> data first, IF next; repeat -> IF first
    rst = 1'b1; tick(); rst = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h200; d_req_i = 1'b1; d_addr_i = 32'h300;
    tick();
    check_eq("t2_first_data", bus_addr_o, 32'h300);
    check_eq("t2_stall_if", 32'(stall_if_o), 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h11111111;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t2_d_ack", 32'(d_ack_o), 32'd1);
    check_eq("t2_d_rdata", d_rdata_o, 32'h11111111);
    check_eq("t2_if_no_ack", 32'(if_ack_o), 32'd0);
    d_req_i = 1'b0;
    tick();
    check_eq("t2_if_granted", bus_addr_o, 32'h200);
    check_eq("t2_if_sel", 32'(bus_sel_o), 32'hF);
    check_eq("t2_if_busreq", 32'(bus_req_o), 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h22222222;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t2_if_ack", 32'(if_ack_o), 32'd1);
    check_eq("t2_if_data", if_data_o, 32'h22222222);
    check_eq("t2_d_untouched", d_rdata_o, 32'h11111111);
    if_req_i = 1'b0;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h204; d_req_i = 1'b1; d_addr_i = 32'h304;
    tick();
    check_eq("t2_rr_if_first", bus_addr_o, 32'h204);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h33333333;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t2_rr_if_data", if_data_o, 32'h33333333);
    if_req_i = 1'b0;
    tick();
    check_eq("t2_rr_data_next", bus_addr_o, 32'h304);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h44444444;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t2_rr_d_rdata", d_rdata_o, 32'h44444444);
    d_req_i = 1'b0;
    tick();

    // 3: data write, bus fields frozen while busy
    d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0010; d_addr_i = 32'h400; d_wdata_i = 32'h00AB00AB;
    tick();
    check_eq("t3_we", 32'(bus_we_o), 32'd1);
    check_eq("t3_sel", 32'(bus_sel_o), 32'h2);
    check_eq("t3_wdata", bus_wdata_o, 32'h00AB00AB);
    d_sel_i = 4'b1111; d_wdata_i = 32'hFFFFFFFF; d_addr_i = 32'h999;
    tick();
    check_eq("t3_sel_hold", 32'(bus_sel_o), 32'h2);
    check_eq("t3_wdata_hold", bus_wdata_o, 32'h00AB00AB);
    check_eq("t3_addr_hold", bus_addr_o, 32'h400);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t3_d_ack", 32'(d_ack_o), 32'd1);
    check_eq("t3_rdata_zero", d_rdata_o, 32'd0);
    d_req_i = 1'b0; d_we_i = 1'b0; d_sel_i = 4'b1111;
    tick();

    // 4: timeout abort after 4 busy cycles, late ack ignored
    d_req_i = 1'b1; d_addr_i = 32'h500;
    tick();
    check_eq("t4_busreq_c1", 32'(bus_req_o), 32'd1);
    tick(); tick(); tick();
    check_eq("t4_busreq_c4", 32'(bus_req_o), 32'd1);
    check_eq("t4_err_c4", 32'(bus_err_o), 32'd0);
    tick();
    check_eq("t4_busreq_drop", 32'(bus_req_o), 32'd0);
    check_eq("t4_d_ack", 32'(d_ack_o), 32'd1);
    check_eq("t4_err", 32'(bus_err_o), 32'd1);
    check_eq("t4_rdata_zero", d_rdata_o, 32'd0);
    d_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h66666666;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t4_late_ack", 32'(d_ack_o), 32'd0);
    check_eq("t4_err_pulse", 32'(bus_err_o), 32'd0);
    check_eq("t4_late_data", d_rdata_o, 32'd0);
    check_eq("t4_idle", 32'(bus_req_o), 32'd0);

    // 4b: ack arriving in the expiry cycle is a normal completion
    d_req_i = 1'b1; d_addr_i = 32'h600;
    tick(); tick(); tick(); tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h77777777;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t4b_d_ack", 32'(d_ack_o), 32'd1);
    check_eq("t4b_rdata", d_rdata_o, 32'h77777777);
    check_eq("t4b_no_err", 32'(bus_err_o), 32'd0);
    d_req_i = 1'b0;
    tick();

    // 5: reset while BUSY_I discards the cycle; held request is re-granted
    if_req_i = 1'b1; if_addr_i = 32'h700;
    tick();
    check_eq("t5_busreq", 32'(bus_req_o), 32'd1);
    rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h88888888;
    tick();
    rst = 1'b0; bus_ack_i = 1'b0;
    check_eq("t5_busreq_rst", 32'(bus_req_o), 32'd0);
    check_eq("t5_no_if_ack", 32'(if_ack_o), 32'd0);
    check_eq("t5_no_err", 32'(bus_err_o), 32'd0);
    tick();
    check_eq("t5_regrant", 32'(bus_req_o), 32'd1);
    check_eq("t5_regrant_addr", bus_addr_o, 32'h700);
    check_eq("t5_no_if_ack2", 32'(if_ack_o), 32'd0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h99999999;
    tick();
    bus_ack_i = 1'b0;
    check_eq("t5_if_ack", 32'(if_ack_o), 32'd1);
    check_eq("t5_if_data", if_data_o, 32'h99999999);
    if_req_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
